// File: rtl/div_unit_if.sv
// Request/response bundle between the execute-stage control path and the divider.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [1:0]      DivOp;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            Flush;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, DivOp, SrcA, SrcB, Flush,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, DivOp, SrcA, SrcB, Flush,
        output Busy, Done, Result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes; signs are fixed up in FIN.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic sel_rem;
    } ctx_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    ctx_t            ctx_q, ctx_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            signed_op;
    logic            a_msb, b_msb;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, ovf;
    logic [XLEN:0]   rem_ext, diff;
    logic [XLEN-1:0] q_fin, r_fin;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        ctx_d     = ctx_q;
        done_d    = 1'b0;
        result_d  = result_q;

        signed_op = ~bus.DivOp[0];
        a_msb     = bus.SrcA[XLEN-1];
        b_msb     = bus.SrcB[XLEN-1];
        a_abs     = (signed_op && a_msb) ? -bus.SrcA : bus.SrcA;
        b_abs     = (signed_op && b_msb) ? -bus.SrcB : bus.SrcB;
        div_zero  = (bus.SrcB == '0);
        ovf       = signed_op && (bus.SrcA == MIN_INT) && (bus.SrcB == '1);

        // Partial remainder is < divisor, so after the shift it needs one extra bit.
        rem_ext   = {rem_q, quo_q[XLEN-1]};
        diff      = rem_ext - {1'b0, dvs_q};
        q_fin     = ctx_q.q_neg ? -quo_q : quo_q;
        r_fin     = ctx_q.r_neg ? -rem_q : rem_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    if (div_zero) begin
                        done_d   = 1'b1;
                        result_d = bus.DivOp[1] ? bus.SrcA : '1;
                    end else if (ovf) begin
                        done_d   = 1'b1;
                        result_d = bus.DivOp[1] ? '0 : MIN_INT;
                    end else begin
                        state_d = CALC;
                        count_d = '0;
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        ctx_d   = '{q_neg:   signed_op && (a_msb ^ b_msb),
                                    r_neg:   signed_op && a_msb,
                                    sel_rem: bus.DivOp[1]};
                    end
                end
            end
            CALC: begin
                if (bus.Flush) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_ext[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                count_d = '0;
                if (!bus.Flush) begin
                    done_d   = 1'b1;
                    result_d = ctx_q.sel_rem ? r_fin : q_fin;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            ctx_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            ctx_q    <= ctx_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.Busy   = (state_q != IDLE);
    assign bus.Done   = done_q;
    assign bus.Result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a latency/RISC-V-arithmetic model checked every cycle,
// plus literal expectations per vector.
module tb_div_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    div_unit_if #(.XLEN(32)) bus();

    div_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // RISC-V M-extension semantics, straight from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: a normal op is busy for XLEN+1 cycles then pulses Done; fast ops pulse Done at once.
    int          m_left   = 0;
    logic        m_done   = 1'b0;
    logic [31:0] m_result = 32'd0;
    logic [31:0] m_pend   = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (bus.Flush) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_done   <= 1'b1;
                        m_result <= m_pend;
                    end
                end
            end else if (bus.Start && !bus.Flush) begin
                if (is_fast(bus.DivOp, bus.SrcA, bus.SrcB)) begin
                    m_done   <= 1'b1;
                    m_result <= ref_div(bus.DivOp, bus.SrcA, bus.SrcB);
                end else begin
                    m_left <= 33;
                    m_pend <= ref_div(bus.DivOp, bus.SrcA, bus.SrcB);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc busy",   {31'd0, bus.Busy}, {31'd0, (m_left != 0)});
        chk("cyc done",   {31'd0, bus.Done}, {31'd0, m_done});
        chk("cyc result", bus.Result, m_result);
    end

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [5:0]  lat;
    } vec_t;

    localparam int NV = 16;
    localparam vec_t VECS [0:NV-1] = '{
        '{2'd0, 32'd100,        32'd7,          32'd14,         6'd33},
        '{2'd2, 32'd100,        32'd7,          32'd2,          6'd33},
        '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  6'd33},
        '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  6'd33},
        '{2'd1, 32'hFFFF_FFFE,  32'd2,          32'h7FFF_FFFF,  6'd33},
        '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  6'd0},
        '{2'd3, 32'd5,          32'd0,          32'd5,          6'd0},
        '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  6'd0},
        '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          6'd0},
        '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  6'd33},
        '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          6'd33},
        '{2'd0, 32'h8000_0000,  32'd2,          32'hC000_0000,  6'd33},
        '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  6'd33},
        '{2'd3, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  6'd33},
        '{2'd0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  6'd0},
        '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  6'd0}
    };

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.DivOp = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
    endtask

    task automatic wait_done(input logic [31:0] exp, input int lat, input string nm);
        int n = 0;
        while (bus.Done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(lat));
        chk({nm, " result"}, bus.Result, exp);
    endtask

    task automatic do_op(input vec_t v, input string nm);
        @(negedge clk);
        issue(v.op, v.a, v.b);
        wait_done(v.exp, int'(v.lat), nm);
    endtask

    initial begin
        int seen;
        bus.Start = 1'b0;
        bus.DivOp = 2'd0;
        bus.SrcA  = 32'd0;
        bus.SrcB  = 32'd0;
        bus.Flush = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy",   {31'd0, bus.Busy}, 32'd0);
        chk("reset done",   {31'd0, bus.Done}, 32'd0);
        chk("reset result", bus.Result, 32'd0);
        rst_n = 1'b1;

        chk("model div 100/7", ref_div(2'd0, 32'd100, 32'd7), 32'd14);
        chk("model rem -7/2",  ref_div(2'd2, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model remu x/0",  ref_div(2'd3, 32'd5, 32'd0), 32'd5);
        chk("model div ovf",   ref_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        for (int i = 0; i < NV; i++) do_op(VECS[i], $sformatf("vec%0d", i));

        // Flush mid-CALC; a Start during Busy must be ignored.
        do_op(VECS[0], "pre-flush");
        @(negedge clk);
        issue(2'd0, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        bus.Start = 1'b1;
        bus.DivOp = 2'd1;
        bus.SrcA  = 32'd9;
        bus.SrcB  = 32'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (5) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        chk("flush busy", {31'd0, bus.Busy}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done) seen++;
        end
        chk("flush no done", 32'(seen), 32'd0);
        chk("flush result held", bus.Result, 32'd14);

        // Flush wins over Start in IDLE.
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.DivOp = 2'd1;
        bus.SrcA  = 32'd5;
        bus.SrcB  = 32'd0;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        chk("idle flush done",   {31'd0, bus.Done}, 32'd0);
        chk("idle flush busy",   {31'd0, bus.Busy}, 32'd0);
        chk("idle flush result", bus.Result, 32'd14);

        // Async reset mid-CALC.
        @(negedge clk);
        issue(2'd0, 32'd100, 32'd7);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy",   {31'd0, bus.Busy}, 32'd0);
        chk("midreset done",   {31'd0, bus.Done}, 32'd0);
        chk("midreset result", bus.Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done) seen++;
        end
        chk("midreset no done", 32'(seen), 32'd0);

        // Back-to-back: new Start in the Done cycle, including fast after normal.
        do_op(VECS[0], "b2b first");
        issue(2'd2, 32'd100, 32'd7);
        wait_done(32'd2, 33, "b2b second");
        issue(2'd1, 32'd5, 32'd0);
        wait_done(32'hFFFF_FFFF, 0, "b2b fast");
        issue(2'd3, 32'd5, 32'd0);
        wait_done(32'd5, 0, "b2b fast2");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
